proc_sysid_checker: RTL and testbench
=====================================

// Module: proc_sysid_checker
// PURPOSE
//  Boot-time consumer of the sysid control slave. Avalon-MM read master that
//  fetches the system ID (address 0) and the build timestamp (address 1),
//  compares both against build-time constants, and retries a bounded number of
//  times on mismatch. Result flags gate scope bring-up and show on status LEDs.
// PARAMETERS
//  EXPECTED_ID    32'hAAAAAAAA  required word at sysid address 0
//  EXPECTED_TS    32'h53699D78  required word at sysid address 1
//  READ_LATENCY   0             extra cycles between read issue and data sample (0..15)
//  MAX_RETRIES    3             re-reads after first mismatch before FAIL (0..15)
//  AUTO_START     1             1: begin a check on the first cycle after reset
// PORTS
//  clock           in   1   system clock
//  reset           in   1   synchronous, active-high reset
//  start           in   1   request a check; sampled only in IDLE, DONE or FAIL
//  sysid_address   out  1   sysid word select: 0 = ID, 1 = timestamp
//  sysid_read      out  1   read strobe to sysid slave
//  sysid_readdata  in   32  sysid slave read data
//  busy            out  1   high from first read cycle until DONE/FAIL entered
//  done            out  1   level: last check finished (pass or fail)
//  match           out  1   level: ID and timestamp both matched (valid with done)
//  id_value        out  32  last ID word sampled
//  ts_value        out  32  last timestamp word sampled
//  retry_count     out  4   re-reads used by the last/current check
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; retry counter and latency counter 0.
//  Reset mid-check aborts immediately; no partial result is kept.
//  States: IDLE, RD_ID, RD_TS, CHECK, DONE, FAIL.
//  IDLE -> RD_ID when start=1, or on the first post-reset cycle if AUTO_START=1.
//  RD_ID: sysid_address=0, sysid_read=1 for READ_LATENCY+1 cycles; readdata is
//   captured into id_value on the last of them; then -> RD_TS.
//  RD_TS: same with sysid_address=1, captured into ts_value; then -> CHECK.
//  CHECK (one cycle, sysid_read=0): match_now = (id_value==EXPECTED_ID) &&
//   (ts_value==EXPECTED_TS), 32-bit exact compare.
//   match_now          -> DONE, match=1
//   !match_now, retry_count<MAX_RETRIES -> retry_count+1, -> RD_ID
//   !match_now, retry_count==MAX_RETRIES -> FAIL, match=0
//  DONE/FAIL: done=1, busy=0, sysid_read=0; start=1 -> RD_ID, clears done,
//   match and retry_count in that same transition (id/ts_value held).
//  start while busy is ignored (no queueing). sysid_read never high outside
//   RD_ID/RD_TS; sysid_address is 0 in all states other than RD_TS.
//  busy=1 in RD_ID, RD_TS, CHECK. retry_count saturates at MAX_RETRIES.
//  Latency, READ_LATENCY=L, no retries: start seen cycle 0 -> done=1 at
//   cycle 2*(L+1)+2.
// TESTING
//  1. AUTO_START=1, L=0, slave returns AAAAAAAA/53699D78 -> read addr0 cyc1,
//     addr1 cyc2, done=1 match=1 retry_count=0 at cyc4.
//  2. ID slave returns 0 always, MAX_RETRIES=3 -> 4 ID/TS read pairs, FAIL,
//     done=1 match=0 retry_count=3, id_value=0.
//  3. First ID read bad, later good -> retry_count=1, done=1 match=1.
//  4. L=2 -> each read strobe held 3 cycles, sample on 3rd; data changing on
//     cycles 1-2 ignored; done at cycle 8 after start.
//  5. reset asserted during RD_TS -> next cycle IDLE, all outputs 0,
//     sysid_read=0; AUTO_START=0 stays IDLE until start.
//  6. start pulsed while busy -> ignored; start in DONE -> done drops next
//     cycle, new check runs to completion.

Source files
------------

// File: rtl/proc_sysid_checker_if.sv
// Avalon-MM read-only port between the sysid checker (master) and the sysid slave.
// The slave has no waitrequest. The master holds sysid_read with a stable sysid_address for
// READ_LATENCY+1 cycles and samples sysid_readdata on the last of those cycles.
interface proc_sysid_checker_if;
    logic        sysid_address;
    logic        sysid_read;
    logic [31:0] sysid_readdata;

    modport master (
        output sysid_address,
        output sysid_read,
        input  sysid_readdata
    );

    modport slave (
        input  sysid_address,
        input  sysid_read,
        output sysid_readdata
    );
endinterface

// File: rtl/proc_sysid_checker.sv
// Boot-time sysid checker: reads the ID and timestamp words, compares them against
// build constants, and retries a bounded number of times before declaring failure.
module proc_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID  = 32'hAAAAAAAA,
    parameter logic [31:0] EXPECTED_TS  = 32'h53699D78,
    parameter int          READ_LATENCY = 0,
    parameter int          MAX_RETRIES  = 3,
    parameter int          AUTO_START   = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    proc_sysid_checker_if.master        sysid,
    output logic                        busy,
    output logic                        done,
    output logic                        match,
    output logic [31:0]                 id_value,
    output logic [31:0]                 ts_value,
    output logic [3:0]                  retry_count,
    output logic [2:0]                  dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_ID = 3'd1,
        S_RD_TS = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4,
        S_FAIL  = 3'd5
    } state_t;

    localparam logic [3:0] LAT_LAST  = 4'(READ_LATENCY);
    localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRIES);

    state_t      state_q;
    logic [3:0]  lat_q;
    logic [3:0]  retry_q;
    logic        auto_q;
    logic        read_q;
    logic        addr_q;
    logic        busy_q;
    logic        done_q;
    logic        match_q;
    logic [31:0] id_q;
    logic [31:0] ts_q;

    logic lat_last;
    logic match_now;

    assign lat_last  = (lat_q == LAT_LAST);
    assign match_now = (id_q == EXPECTED_ID) && (ts_q == EXPECTED_TS);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            lat_q   <= 4'd0;
            retry_q <= 4'd0;
            auto_q  <= (AUTO_START != 0);
            read_q  <= 1'b0;
            addr_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
            id_q    <= 32'd0;
            ts_q    <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start || auto_q) begin
                        state_q <= S_RD_ID;
                        auto_q  <= 1'b0;
                        lat_q   <= 4'd0;
                        retry_q <= 4'd0;
                        read_q  <= 1'b1;
                        addr_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                S_RD_ID: begin
                    if (lat_last) begin
                        id_q    <= sysid.sysid_readdata;
                        state_q <= S_RD_TS;
                        addr_q  <= 1'b1;
                        lat_q   <= 4'd0;
                    end else begin
                        lat_q <= lat_q + 4'd1;
                    end
                end
                S_RD_TS: begin
                    if (lat_last) begin
                        ts_q    <= sysid.sysid_readdata;
                        state_q <= S_CHECK;
                        read_q  <= 1'b0;
                        addr_q  <= 1'b0;
                        lat_q   <= 4'd0;
                    end else begin
                        lat_q <= lat_q + 4'd1;
                    end
                end
                S_CHECK: begin
                    // Retry counter only advances below the limit, so it saturates there.
                    if (match_now) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        match_q <= 1'b1;
                    end else if (retry_q < RETRY_MAX) begin
                        state_q <= S_RD_ID;
                        retry_q <= retry_q + 4'd1;
                        read_q  <= 1'b1;
                        addr_q  <= 1'b0;
                        lat_q   <= 4'd0;
                    end else begin
                        state_q <= S_FAIL;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        match_q <= 1'b0;
                    end
                end
                S_DONE, S_FAIL: begin
                    if (start) begin
                        state_q <= S_RD_ID;
                        lat_q   <= 4'd0;
                        retry_q <= 4'd0;
                        read_q  <= 1'b1;
                        addr_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        match_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    read_q  <= 1'b0;
                    addr_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sysid.sysid_read    = read_q;
    assign sysid.sysid_address = addr_q;
    assign busy                = busy_q;
    assign done                = done_q;
    assign match               = match_q;
    assign id_value            = id_q;
    assign ts_value            = ts_q;
    assign retry_count         = retry_q;
    assign dbg_state_o         = state_q;

endmodule

// File: tb/tb_proc_sysid_checker.sv
// Bench for proc_sysid_checker: an auto-start L=0 instance for the pass, fail and retry flows,
// and a manual-start L=2 instance for read latency and mid-check reset.
module tb_proc_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'hAAAAAAAA;
    localparam logic [31:0] EXP_TS = 32'h53699D78;
    localparam int          SB_W   = 69;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Instance A: AUTO_START=1, READ_LATENCY=0
    logic        reset_a, start_a;
    logic        busy_a, done_a, match_a;
    logic [31:0] id_a, ts_a;
    logic [3:0]  retry_a;
    logic [2:0]  state_a;
    proc_sysid_checker_if bus_a ();

    // Instance B: AUTO_START=0, READ_LATENCY=2
    logic        reset_b, start_b;
    logic        busy_b, done_b, match_b;
    logic [31:0] id_b, ts_b;
    logic [3:0]  retry_b;
    logic [2:0]  state_b;
    proc_sysid_checker_if bus_b ();

    proc_sysid_checker #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS),
        .READ_LATENCY(0), .MAX_RETRIES(3), .AUTO_START(1)
    ) u_dut_a (
        .clock(clock), .reset(reset_a), .start(start_a), .sysid(bus_a),
        .busy(busy_a), .done(done_a), .match(match_a),
        .id_value(id_a), .ts_value(ts_a), .retry_count(retry_a), .dbg_state_o(state_a)
    );

    proc_sysid_checker #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS),
        .READ_LATENCY(2), .MAX_RETRIES(3), .AUTO_START(0)
    ) u_dut_b (
        .clock(clock), .reset(reset_b), .start(start_b), .sysid(bus_b),
        .busy(busy_b), .done(done_b), .match(match_b),
        .id_value(id_b), .ts_value(ts_b), .retry_count(retry_b), .dbg_state_o(state_b)
    );

    // Slave A: ID reads numbered 1..n_bad_a return zero, later ones return id_word_a.
    logic [31:0] id_word_a, ts_word_a, rd_b;
    int          n_bad_a, id_reads, ts_reads, cycles_a;
    assign bus_a.sysid_readdata = bus_a.sysid_address ? ts_word_a :
                                  ((id_reads <= n_bad_a) ? 32'h0 : id_word_a);
    assign bus_b.sysid_readdata = rd_b;

    int n_vec = 0;
    int n_err = 0;
    logic [SB_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step_a();
        @(negedge clock);
        cycles_a++;
        if (bus_a.sysid_read && !bus_a.sysid_address) id_reads++;
        if (bus_a.sysid_read && bus_a.sysid_address) ts_reads++;
    endtask

    task automatic sb_pop(input string tag, input logic m, input logic [3:0] r,
                          input logic [31:0] idv, input logic [31:0] tsv);
        logic [SB_W-1:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_match"}, 64'(m), 64'(e[68]));
            check({tag, "_retry"}, 64'(r), 64'(e[67:64]));
            check({tag, "_id"}, 64'(idv), 64'(e[63:32]));
            check({tag, "_ts"}, 64'(tsv), 64'(e[31:0]));
        end
    endtask

    task automatic run_a(input string tag, input int n_bad, input logic [3:0] exp_retry,
                         input logic exp_match, input logic [31:0] exp_id, input bit poke);
        int lat_exp;
        lat_exp  = (int'(exp_retry) + 1) * 3 + 1;
        n_bad_a  = n_bad;
        id_reads = 0;
        ts_reads = 0;
        cycles_a = 0;
        exp_q.push_back({exp_match, exp_retry, exp_id, ts_word_a});
        start_a = 1'b1;
        step_a();
        start_a = 1'b0;
        check({tag, "_done_clr"}, 64'(done_a), 64'd0);
        check({tag, "_retry_clr"}, 64'(retry_a), 64'd0);
        check({tag, "_rd_id"}, 64'({bus_a.sysid_read, bus_a.sysid_address}), 64'b10);
        while (!done_a && cycles_a < 100) begin
            if (poke && cycles_a == 2) start_a = 1'b1;
            step_a();
            start_a = 1'b0;
        end
        check({tag, "_done"}, 64'(done_a), 64'd1);
        sb_pop(tag, match_a, retry_a, id_a, ts_a);
        check({tag, "_latency"}, 64'(cycles_a), 64'(lat_exp));
        check({tag, "_id_reads"}, 64'(id_reads), 64'(int'(exp_retry) + 1));
        check({tag, "_ts_reads"}, 64'(ts_reads), 64'(int'(exp_retry) + 1));
        if (poke) begin
            repeat (3) step_a();
            check({tag, "_busy_start_ignored"}, 64'(done_a), 64'd1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        exp_rd, exp_ad, exp_busy, exp_done;
        logic [31:0] garbage;
        reset_a = 1'b1; reset_b = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        id_word_a = EXP_ID; ts_word_a = EXP_TS;
        n_bad_a = 0; id_reads = 0; ts_reads = 0; cycles_a = 0;
        rd_b = 32'h0;
        repeat (3) step_a();

        // Reset state
        check("rst_state", 64'(state_a), 64'd0);
        check("rst_outs", 64'({busy_a, done_a, match_a, bus_a.sysid_read, bus_a.sysid_address}), 64'd0);
        check("rst_vals", {id_a, ts_a}, 64'd0);
        check("rst_retry", 64'(retry_a), 64'd0);

        // Auto-start pass with L=0
        exp_q.push_back({1'b1, 4'd0, EXP_ID, EXP_TS});
        reset_a = 1'b0; reset_b = 1'b0;
        cycles_a = 0;
        step_a();
        check("t1_c1", 64'({busy_a, bus_a.sysid_read, bus_a.sysid_address}), 64'b110);
        step_a();
        check("t1_c2", 64'({busy_a, bus_a.sysid_read, bus_a.sysid_address}), 64'b111);
        step_a();
        check("t1_c3", 64'({busy_a, bus_a.sysid_read, done_a}), 64'b100);
        check("t1_c3_state", 64'(state_a), 64'd3);
        step_a();
        check("t1_c4", 64'({done_a, busy_a, bus_a.sysid_read}), 64'b100);
        check("t1_c4_state", 64'(state_a), 64'd4);
        sb_pop("t1", match_a, retry_a, id_a, ts_a);

        // ID always wrong: exhaust retries, start pulsed while busy must be ignored
        run_a("t2", 1000, 4'd3, 1'b0, 32'h0, 1'b1);
        check("t2_state", 64'(state_a), 64'd5);
        // First ID read bad, restart from FAIL
        run_a("t3", 1, 4'd1, 1'b1, EXP_ID, 1'b0);
        run_a("t3b", 2, 4'd2, 1'b1, EXP_ID, 1'b0);
        // Timestamp off by one bit
        ts_word_a = EXP_TS ^ 32'h1;
        run_a("t_ts", 0, 4'd3, 1'b0, EXP_ID, 1'b0);
        ts_word_a = EXP_TS;
        run_a("t_again", 0, 4'd0, 1'b1, EXP_ID, 1'b0);

        // Instance B stays idle without start
        check("b_idle_state", 64'(state_b), 64'd0);
        check("b_idle_outs", 64'({busy_b, done_b, bus_b.sysid_read}), 64'd0);

        // L=2: strobe held 3 cycles, only the third sample counts
        exp_q.push_back({1'b1, 4'd0, EXP_ID, EXP_TS});
        start_b = 1'b1;
        rd_b = $urandom;
        @(negedge clock);
        start_b = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            exp_rd   = (k <= 6);
            exp_ad   = (k >= 4 && k <= 6);
            exp_busy = (k <= 7);
            exp_done = (k == 8);
            check($sformatf("t4_c%0d", k),
                  64'({bus_b.sysid_read, bus_b.sysid_address, busy_b, done_b}),
                  64'({exp_rd, exp_ad, exp_busy, exp_done}));
            garbage = $urandom_range(32'h7FFFFFFF, 0);
            rd_b = (k == 3) ? EXP_ID : ((k == 6) ? EXP_TS : garbage);
            if (k == 8) sb_pop("t4", match_b, retry_b, id_b, ts_b);
            else @(negedge clock);
        end

        // Reset during RD_TS aborts with nothing kept
        start_b = 1'b1;
        @(negedge clock);
        start_b = 1'b0;
        repeat (3) @(negedge clock);
        check("t5_in_rd_ts", 64'(state_b), 64'd2);
        reset_b = 1'b1;
        @(negedge clock);
        check("t5_rst_state", 64'(state_b), 64'd0);
        check("t5_rst_outs",
              64'({busy_b, done_b, match_b, bus_b.sysid_read, bus_b.sysid_address, retry_b}), 64'd0);
        check("t5_rst_vals", {id_b, ts_b}, 64'd0);
        reset_b = 1'b0;
        repeat (4) @(negedge clock);
        check("t5_stay_idle", 64'({state_b, busy_b, bus_b.sysid_read}), 64'd0);
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
